vmem_responder: RTL

Memory-side responder for the core's fetch and load/store port. It accepts one request at a time over a valid/ready handshake and performs the access through the `npc_vmem_read` / `npc_vmem_write` DPI functions. It returns the read data after a programmable fixed latency over a second valid/ready handshake. It replaces zero-latency combinational memory reads so the core's multi-cycle fetch/LSU initiator can be exercised against a realistic slave.

---
 rtl/vmem_responder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/vmem_responder.sv
// vmem_responder: memory-side responder for the core's fetch and load/store port.
// It accepts one request at a time over a valid/ready handshake. After a fixed
// LATENCY it performs a single word access on the memory port and returns the
// result over a second valid/ready handshake.
//
// Ports
//   i_clk, i_rst        clock; synchronous active-low reset
//   i_req_*             request channel (valid/ready, addr, wen, wdata, wmask)
//   o_req_ready         responder can accept a request (combinational)
//   o_resp_*            response channel (valid, rdata, wen echo), registered
//   i_resp_ready        initiator consumes the response
//   o_busy              high in any state other than IDLE
//   o_mem_*_c           memory access strobe and payload for the
//                       npc_vmem_read/npc_vmem_write functions (combinational)
//   i_mem_rdata         word returned by npc_vmem_read for o_mem_addr_c
module vmem_responder #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DATA_W  = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [63:0]       i_req_addr,
  input  logic              i_req_wen,
  input  logic [DATA_W-1:0] i_req_wdata,
  input  logic [7:0]        i_req_wmask,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_wen,
  output logic              o_busy,
  output logic              o_mem_en_c,
  output logic              o_mem_we_c,
  output logic [63:0]       o_mem_addr_c,
  output logic [DATA_W-1:0] o_mem_wdata_c,
  output logic [7:0]        o_mem_wmask_c,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [63:0]       r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [7:0]        r_wmask;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_wen;

  logic              w_accept;
  logic              w_access;
  logic              w_use_req;
  logic [63:0]       w_addr_sel;

  // Handshake qualifiers; reset masks both acceptance and the memory access.
  assign o_req_ready = i_rst && (r_state == S_IDLE);
  assign w_accept    = o_req_ready && i_req_valid;

  // The access happens on the edge where the counter reaches zero; with
  // LATENCY=1 that is the accept edge itself, so the live request is used.
  assign w_access  = i_rst && ((w_accept && (CNT_LOAD == '0)) ||
                               ((r_state == S_WAIT) && (r_cnt <= CNT_W'(1))));
  assign w_use_req = (r_state == S_IDLE);

  // Memory port: word-aligned address, payload from the request or the latch.
  assign w_addr_sel    = w_use_req ? i_req_addr : r_addr;
  assign o_mem_en_c    = w_access;
  assign o_mem_we_c    = w_use_req ? i_req_wen   : r_wen;
  assign o_mem_addr_c  = w_addr_sel & ~64'd7;
  assign o_mem_wdata_c = w_use_req ? i_req_wdata : r_wdata;
  assign o_mem_wmask_c = w_use_req ? i_req_wmask : r_wmask;

  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_wen   = r_resp_wen;
  assign o_busy       = (r_state != S_IDLE);

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (CNT_LOAD == '0) ? S_RESP : S_WAIT;
      S_WAIT: if (w_access) w_state_nxt = S_RESP;
      S_RESP: if (i_resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Request latch, latency counter and response registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_wen   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= i_req_addr;
        r_wen   <= i_req_wen;
        r_wdata <= i_req_wdata;
        r_wmask <= i_req_wmask;
        r_cnt   <= CNT_LOAD;
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      if (w_access) begin
        r_resp_valid <= 1'b1;
        r_resp_wen   <= o_mem_we_c;
        r_resp_rdata <= o_mem_we_c ? '0 : i_mem_rdata;
      end else if ((r_state == S_RESP) && i_resp_ready) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

endmodule
